// File: rtl/uparc_fetch_pkg.sv
// Shared constants and types for the Ultiparc fetch sequencer.
// Error flag bit positions match the {bus, align} layout of o_err.
package uparc_fetch_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int ERR_WIDTH   = 2;

  localparam logic [ADDR_WIDTH-1:0] INSTR_SIZE = 32'd4;

  localparam int UPARC_FETCH_ERR_ALIGN = 0;
  localparam int UPARC_FETCH_ERR_BUS   = 1;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_DRAIN = 2'd1,
    FETCH_HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ERR_WIDTH-1:0]   err;
  } fetch_entry_t;

  localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

  // A faulting fetch carries no usable instruction word.
  function automatic fetch_entry_t make_entry(
    input logic [INSTR_WIDTH-1:0] instr,
    input logic [ADDR_WIDTH-1:0]  pc,
    input logic [ERR_WIDTH-1:0]   err
  );
    fetch_entry_t e;
    e.instr = (err != '0) ? '0 : instr;
    e.pc    = pc;
    e.err   = err;
    return e;
  endfunction

endpackage

// File: rtl/uparc_fetch_skid.sv
// One-entry skid register for the fetch sequencer: holds an instruction
// fetched while decode stalls so the output refills without a bubble.
module uparc_fetch_skid
  import uparc_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   flush,
  input  logic                   load,
  input  logic                   pop,
  input  logic [ENTRY_WIDTH-1:0] din,
  output logic                   full,
  output logic [ENTRY_WIDTH-1:0] dout
);

  logic                   full_reg;
  logic [ENTRY_WIDTH-1:0] entry_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      full_reg  <= 1'b0;
      entry_reg <= '0;
    end else if (flush) begin
      full_reg <= 1'b0;
    end else if (load) begin
      full_reg  <= 1'b1;
      entry_reg <= din;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign full = full_reg;
  assign dout = entry_reg;

endmodule

// File: rtl/uparc_fetch.sv
// Ultiparc instruction fetch sequencer: PC ownership, IFU command issue,
// redirect/drain handling and registered valid/stall output to decode.
// Optional skid buffer enabled by defining UPARC_FETCH_SKID_EN.
module uparc_fetch
  import uparc_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   nrst,
  output logic [ADDR_WIDTH-1:0]  o_addr,
  output logic                   o_rd_cmd,
  input  logic [INSTR_WIDTH-1:0] i_instr_dat,
  input  logic                   i_busy,
  input  logic                   i_err_align,
  input  logic                   i_err_bus,
  input  logic                   i_stall,
  input  logic                   i_redir,
  input  logic [ADDR_WIDTH-1:0]  i_redir_addr,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ERR_WIDTH-1:0]   o_err
);

  fetch_state_t          state_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] hold_reg;
  logic                  valid_reg;
  fetch_entry_t          out_reg;

  logic                  out_free;
  logic                  issue_ok;
  logic                  cmd_raw;
  logic                  rd_cmd;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ERR_WIDTH-1:0]  ifu_err;
  logic                  done;
  logic                  load_entry;
  fetch_entry_t          entry;
  logic                  skid_full;
  fetch_entry_t          skid_entry;

  assign out_free = !valid_reg || !i_stall;

`ifdef UPARC_FETCH_SKID_EN
  logic                   skid_load;
  logic                   skid_pop;
  logic [ENTRY_WIDTH-1:0] skid_dout;

  assign skid_load = load_entry && !out_free;
  assign skid_pop  = out_free && skid_full;
  assign issue_ok  = !skid_full;

  uparc_fetch_skid u_skid (
    .clk  (clk),
    .nrst (nrst),
    .flush(i_redir),
    .load (skid_load),
    .pop  (skid_pop),
    .din  (entry),
    .full (skid_full),
    .dout (skid_dout)
  );

  assign skid_entry = fetch_entry_t'(skid_dout);
`else
  assign skid_full  = 1'b0;
  assign skid_entry = '0;
  assign issue_ok   = out_free;
`endif

  always_comb begin
    cmd_raw  = 1'b0;
    cur_addr = pc_reg;
    case (state_reg)
      FETCH_RUN:   cmd_raw = issue_ok;
      FETCH_DRAIN: begin
        cmd_raw  = 1'b1;
        cur_addr = hold_reg;
      end
      default:     cmd_raw = 1'b0;
    endcase
  end

  // No command leaves the block while reset is held.
  assign rd_cmd   = cmd_raw && nrst;
  assign o_rd_cmd = rd_cmd;
  assign o_addr   = rd_cmd ? cur_addr : '0;

  always_comb begin
    ifu_err                        = '0;
    ifu_err[UPARC_FETCH_ERR_ALIGN] = i_err_align;
    ifu_err[UPARC_FETCH_ERR_BUS]   = i_err_bus;
  end

  assign done       = rd_cmd && (!i_busy || (ifu_err != '0));
  assign load_entry = done && (state_reg == FETCH_RUN) && !i_redir;
  assign entry      = make_entry(i_instr_dat, pc_reg, ifu_err);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= FETCH_RUN;
      pc_reg    <= RESET_VECTOR;
      hold_reg  <= '0;
      valid_reg <= 1'b0;
      out_reg   <= '0;
    end else if (i_redir) begin
      pc_reg    <= i_redir_addr;
      valid_reg <= 1'b0;
      // A transfer still in flight must finish before the target is fetched.
      if (rd_cmd && !done) begin
        state_reg <= FETCH_DRAIN;
        hold_reg  <= cur_addr;
      end else begin
        state_reg <= FETCH_RUN;
      end
    end else begin
      case (state_reg)
        FETCH_RUN: begin
          if (load_entry) begin
            if (ifu_err != '0) state_reg <= FETCH_HALT;
            else               pc_reg    <= pc_reg + INSTR_SIZE;
          end
        end
        FETCH_DRAIN: begin
          if (done) state_reg <= FETCH_RUN;
        end
        default: ;
      endcase

      if (out_free) begin
        if (skid_full) begin
          out_reg   <= skid_entry;
          valid_reg <= 1'b1;
        end else if (load_entry) begin
          out_reg   <= entry;
          valid_reg <= 1'b1;
        end else begin
          valid_reg <= 1'b0;
        end
      end
    end
  end

  assign o_valid = valid_reg;
  assign o_instr = out_reg.instr;
  assign o_pc    = out_reg.pc;
  assign o_err   = out_reg.err;

endmodule

// File: tb/tb_uparc_fetch.sv
// Self-checking bench for uparc_fetch: IFU model with programmable wait
// states, scoreboard of expected decode-side entries, scenario tasks.
module tb_uparc_fetch;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] o_addr;
  logic        o_rd_cmd;
  logic [31:0] i_instr_dat = 32'h0;
  logic        i_busy = 1'b0;
  logic        i_err_align = 1'b0;
  logic        i_err_bus = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redir = 1'b0;
  logic [31:0] i_redir_addr = 32'h0;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [1:0]  o_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  err;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  // IFU model controls (written by tasks) and private state.
  logic [31:0] wait_addr = 32'hFFFF_FFFF;
  int          wait_n = 0;
  int          arm_seq = 0;
  int          arm_seen = 0;
  int          busy_seen = 0;
  bit          armed = 1'b0;

  uparc_fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .o_addr      (o_addr),
    .o_rd_cmd    (o_rd_cmd),
    .i_instr_dat (i_instr_dat),
    .i_busy      (i_busy),
    .i_err_align (i_err_align),
    .i_err_bus   (i_err_bus),
    .i_stall     (i_stall),
    .i_redir     (i_redir),
    .i_redir_addr(i_redir_addr),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ifu_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // IFU: responds at mid-cycle to the command currently presented.
  always @(negedge clk) begin
    if (arm_seq != arm_seen) begin
      arm_seen  = arm_seq;
      busy_seen = 0;
      armed     = 1'b1;
    end
    i_instr_dat = ifu_data(o_addr);
    i_err_align = o_rd_cmd && (o_addr[1:0] != 2'b00);
    i_err_bus   = 1'b0;
    i_busy      = 1'b0;
    if (armed && o_rd_cmd && o_addr == wait_addr) begin
      if (busy_seen < wait_n) begin
        i_busy = 1'b1;
        busy_seen++;
      end else begin
        armed = 1'b0;
      end
    end
  end

  // Scoreboard: each entry decode accepts is compared against the queue head.
  always @(negedge clk) begin
    if (nrst && o_valid && !i_stall && sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      checks++;
      if (o_instr !== sb_e.instr || o_pc !== sb_e.pc || o_err !== sb_e.err) begin
        errors++;
        $display("FAIL sb_entry got pc=%h instr=%h err=%b expected pc=%h instr=%h err=%b",
                 o_pc, o_instr, o_err, sb_e.pc, sb_e.instr, sb_e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic push_ok(input logic [31:0] pc);
    exp_t e;
    e.instr = ifu_data(pc);
    e.pc    = pc;
    e.err   = 2'b00;
    sb_q.push_back(e);
  endtask

  task automatic push_err(input logic [31:0] pc, input logic [1:0] err);
    exp_t e;
    e.instr = 32'h0;
    e.pc    = pc;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic arm_wait(input logic [31:0] addr, input int n);
    wait_addr = addr;
    wait_n    = n;
    arm_seq++;
  endtask

  // Leaves the bench at the start of the first cycle after reset release.
  task automatic do_reset;
    sb_q.delete();
    wait_addr    = 32'hFFFF_FFFF;
    wait_n       = 0;
    i_stall      = 1'b0;
    i_redir      = 1'b0;
    i_redir_addr = 32'h0;
    nrst         = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic test_reset;
    i_stall = 1'b0;
    i_redir = 1'b0;
    nrst    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_valid, o_rd_cmd} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl valid/rd_cmd=%b required 00", {o_valid, o_rd_cmd});
    end
    checks++;
    if (o_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr got %h required 00000000", o_addr);
    end
    checks++;
    if (o_instr !== 32'h0 || o_pc !== 32'h0 || o_err !== 2'b00) begin
      errors++;
      $display("FAIL reset_entry got instr=%h pc=%h err=%b required zeros", o_instr, o_pc, o_err);
    end
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_rd_cmd !== 1'b1 || o_addr !== 32'h100) begin
      errors++;
      $display("FAIL first_cmd got rd_cmd=%b addr=%h required 1 00000100", o_rd_cmd, o_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_zero_wait;
    do_reset();
    push_ok(32'h100);
    push_ok(32'h104);
    push_ok(32'h108);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h100 + 32'(4 * k) || o_err !== 2'b00) begin
        errors++;
        $display("FAIL zero_wait_stream cycle %0d got valid=%b pc=%h err=%b required 1 %h 00",
                 k, o_valid, o_pc, o_err, 32'h100 + 32'(4 * k));
      end
      next_cycle();
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL zero_wait_drain left %0d required 0", sb_q.size());
    end
    $display("test_zero_wait done");
  endtask

  task automatic test_wait_states;
    int n_cmd = 0;
    int last_cmd = -1;
    int valid_at = -1;
    do_reset();
    push_ok(32'h100);
    push_ok(32'h104);
    push_ok(32'h108);
    arm_wait(32'h104, 3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_rd_cmd && o_addr == 32'h104) begin
        n_cmd++;
        last_cmd = c;
      end
      if (o_valid && o_pc == 32'h104 && valid_at < 0) valid_at = c;
      next_cycle();
    end
    checks++;
    if (n_cmd != 4) begin
      errors++;
      $display("FAIL wait_cmd_cycles got %0d required 4", n_cmd);
    end
    checks++;
    if (valid_at != 5 || valid_at != last_cmd + 1) begin
      errors++;
      $display("FAIL wait_valid_cycle got %0d (last cmd %0d) required 5", valid_at, last_cmd);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL wait_drain left %0d required 0", sb_q.size());
    end
    $display("test_wait_states done");
  endtask

  task automatic test_stall;
    int n_cmd = 0;
    int exp_cmd;
`ifdef UPARC_FETCH_SKID_EN
    exp_cmd = 1;
`else
    exp_cmd = 0;
`endif
    do_reset();
    push_ok(32'h100);
    push_ok(32'h104);
    push_ok(32'h108);
    push_ok(32'h10C);
    push_ok(32'h110);
    next_cycle();
    next_cycle();
    i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h104 || o_instr !== ifu_data(32'h104)) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b pc=%h instr=%h required 1 00000104 %h",
                 i, o_valid, o_pc, o_instr, ifu_data(32'h104));
      end
      if (o_rd_cmd) n_cmd++;
      next_cycle();
    end
    i_stall = 1'b0;
    checks++;
    if (n_cmd != exp_cmd) begin
      errors++;
      $display("FAIL stall_fetches got %0d required %0d", n_cmd, exp_cmd);
    end
    repeat (8) next_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain left %0d required 0", sb_q.size());
    end
    $display("test_stall done");
  endtask

  task automatic test_redirect_drain;
    do_reset();
    push_ok(32'h100);
    push_ok(32'h2000);
    push_ok(32'h2004);
    arm_wait(32'h104, 3);
    next_cycle();
    next_cycle();
    i_redir      = 1'b1;
    i_redir_addr = 32'h2000;
    next_cycle();
    i_redir = 1'b0;
    @(negedge clk);
    checks++;
    if (o_rd_cmd !== 1'b1 || o_addr !== 32'h104 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_hold1 got rd_cmd=%b addr=%h valid=%b required 1 00000104 0",
               o_rd_cmd, o_addr, o_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (o_rd_cmd !== 1'b1 || o_addr !== 32'h104) begin
      errors++;
      $display("FAIL drain_hold2 got rd_cmd=%b addr=%h required 1 00000104", o_rd_cmd, o_addr);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_rd_cmd !== 1'b1 || o_addr !== 32'h2000) begin
      errors++;
      $display("FAIL drain_target got valid=%b rd_cmd=%b addr=%h required 0 1 00002000",
               o_valid, o_rd_cmd, o_addr);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h2000) begin
      errors++;
      $display("FAIL drain_first_valid got valid=%b pc=%h required 1 00002000", o_valid, o_pc);
    end
    repeat (4) next_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_sb_drain left %0d required 0", sb_q.size());
    end
    $display("test_redirect_drain done");
  endtask

  task automatic test_align_halt;
    int n_cmd = 0;
    do_reset();
    push_ok(32'h100);
    push_err(32'h2002, 2'b01);
    push_ok(32'h3000);
    push_ok(32'h3004);
    next_cycle();
    i_redir      = 1'b1;
    i_redir_addr = 32'h2002;
    next_cycle();
    i_redir = 1'b0;
    @(negedge clk);
    checks++;
    if (o_rd_cmd !== 1'b1 || o_addr !== 32'h2002) begin
      errors++;
      $display("FAIL align_cmd got rd_cmd=%b addr=%h required 1 00002002", o_rd_cmd, o_addr);
    end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_rd_cmd || o_addr != 32'h0) n_cmd++;
      next_cycle();
    end
    checks++;
    if (n_cmd != 0) begin
      errors++;
      $display("FAIL halt_no_cmd got %0d active cycles required 0", n_cmd);
    end
    i_redir      = 1'b1;
    i_redir_addr = 32'h3000;
    next_cycle();
    i_redir = 1'b0;
    @(negedge clk);
    checks++;
    if (o_rd_cmd !== 1'b1 || o_addr !== 32'h3000) begin
      errors++;
      $display("FAIL halt_resume got rd_cmd=%b addr=%h required 1 00003000", o_rd_cmd, o_addr);
    end
    repeat (4) next_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL align_drain left %0d required 0", sb_q.size());
    end
    $display("test_align_halt done");
  endtask

  task automatic test_wrap;
    do_reset();
    push_ok(32'h100);
    push_ok(32'hFFFF_FFF8);
    push_ok(32'hFFFF_FFFC);
    push_ok(32'h0000_0000);
    push_ok(32'h0000_0004);
    next_cycle();
    i_redir      = 1'b1;
    i_redir_addr = 32'hFFFF_FFF8;
    next_cycle();
    i_redir = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (o_rd_cmd !== 1'b1 || o_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr got rd_cmd=%b addr=%h required 1 00000000", o_rd_cmd, o_addr);
    end
    repeat (5) next_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_drain left %0d required 0", sb_q.size());
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    arm_wait(32'h104, 5);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (o_rd_cmd !== 1'b1 || o_addr !== 32'h104) begin
      errors++;
      $display("FAIL midwait_pre got rd_cmd=%b addr=%h required 1 00000104", o_rd_cmd, o_addr);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_rd_cmd !== 1'b0 || o_addr !== 32'h0 ||
        o_instr !== 32'h0 || o_pc !== 32'h0 || o_err !== 2'b00) begin
      errors++;
      $display("FAIL midwait_reset got valid=%b rd_cmd=%b addr=%h instr=%h pc=%h err=%b required all zero",
               o_valid, o_rd_cmd, o_addr, o_instr, o_pc, o_err);
    end
    wait_addr = 32'hFFFF_FFFF;
    wait_n    = 0;
    repeat (2) @(posedge clk);
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_drain();
    test_align_halt();
    test_wrap();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
